// File: rtl/btn_input_conditioner.sv
// ---------------------------------------------------------------------------
// btn_input_conditioner
//
// Conditions the raw front-panel buttons before the core sees them. Each
// button gets its own channel:
//   - a 2-FF synchroniser on the asynchronous pad level;
//   - a polarity normalisation, so that 1 always means pressed;
//   - a counter-based debouncer that accepts a new level only after it has
//     been held for DEBOUNCE_CYCLES consecutive edges;
//   - registered one-cycle press/release event pulses;
//   - a sticky interrupt-pending bit that is set by a press and cleared by a
//     per-bit acknowledge.
// The pending bits, masked by irq_en, are ORed into a single level interrupt.
//
// Ports:
//   core_clk     in   1        system clock, rising edge
//   core_rst     in   1        synchronous active-high reset
//   btn_in       in   NUM_BTN  raw asynchronous pad levels
//   btn_state    out  NUM_BTN  debounced state, 1 = pressed
//   press_evt    out  NUM_BTN  one-cycle pulse on btn_state 0->1
//   release_evt  out  NUM_BTN  one-cycle pulse on btn_state 1->0
//   irq_en       in   NUM_BTN  per-button interrupt enable
//   irq_ack      in   NUM_BTN  per-bit clear of irq_pend
//   irq_pend     out  NUM_BTN  sticky pending bits, set by press_evt
//   irq          out  1        OR of (irq_pend & irq_en)
// ---------------------------------------------------------------------------
module btn_input_conditioner #(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = 48000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic               core_clk,
   input  logic               core_rst,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_BTN-1:0] btn_state,
   output logic [NUM_BTN-1:0] press_evt,
   output logic [NUM_BTN-1:0] release_evt,
   input  logic [NUM_BTN-1:0] irq_en,
   input  logic [NUM_BTN-1:0] irq_ack,
   output logic [NUM_BTN-1:0] irq_pend,
   output logic               irq
);

   // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice and
   // it is always cleared before it could wrap.
   localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   // Pad level of a released button; the synchroniser starts here so that
   // reset does not look like a press.
   localparam logic              REL_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   generate
      for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
         logic             sync1_reg;
         logic             sync2_reg;
         logic             level;
         logic [CNT_W-1:0] cnt_reg;
         logic             state_reg;
         logic             press_reg;
         logic             release_reg;
         logic             pend_reg;

         // Normalised, synchronised level: 1 = pressed.
         assign level = (ACTIVE_LOW != 0) ? ~sync2_reg : sync2_reg;

         always_ff @(posedge core_clk) begin
            if (core_rst) begin
               sync1_reg   <= REL_LEVEL;
               sync2_reg   <= REL_LEVEL;
               cnt_reg     <= '0;
               state_reg   <= 1'b0;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;
               pend_reg    <= 1'b0;
            end else begin
               sync1_reg   <= btn_in[gi];
               sync2_reg   <= sync1_reg;
               press_reg   <= 1'b0;
               release_reg <= 1'b0;

               // Debounce: a differing level must survive CNT_MAX+1 edges in
               // a row; any return to the accepted level restarts the count.
               if (level != state_reg) begin
                  if (cnt_reg == CNT_MAX) begin
                     state_reg   <= level;
                     cnt_reg     <= '0;
                     // Events are registered alongside the state so they are
                     // high exactly in the first cycle of the new state.
                     press_reg   <= level;
                     release_reg <= ~level;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end else begin
                  cnt_reg <= '0;
               end

               // Set has priority over acknowledge so a press arriving in the
               // same cycle as an ack is never lost.
               if (press_reg) begin
                  pend_reg <= 1'b1;
               end else if (irq_ack[gi]) begin
                  pend_reg <= 1'b0;
               end
            end
         end

         assign btn_state[gi]   = state_reg;
         assign press_evt[gi]   = press_reg;
         assign release_evt[gi] = release_reg;
         assign irq_pend[gi]    = pend_reg;
      end
   endgenerate

   // Mask only gates the request, not the pending bits, so enabling an
   // already-pending bit raises irq immediately.
   assign irq = |(irq_pend & irq_en);

endmodule

// File: tb/tb_btn_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_btn_input_conditioner
//
// Directed bench for btn_input_conditioner with NUM_BTN=5,
// DEBOUNCE_CYCLES=4, ACTIVE_LOW=1. Expected values are hand-computed from
// the debounce timing: a level captured at edge 1 changes btn_state at edge 6.
// ---------------------------------------------------------------------------
module tb_btn_input_conditioner;

   logic       core_clk;
   logic       core_rst;
   logic [4:0] btn_in;
   logic [4:0] btn_state;
   logic [4:0] press_evt;
   logic [4:0] release_evt;
   logic [4:0] irq_en;
   logic [4:0] irq_ack;
   logic [4:0] irq_pend;
   logic       irq;

   int tests_run;
   int tests_failed;

   btn_input_conditioner #(
      .NUM_BTN         (5),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1)
   ) dut (
      .core_clk    (core_clk),
      .core_rst    (core_rst),
      .btn_in      (btn_in),
      .btn_state   (btn_state),
      .press_evt   (press_evt),
      .release_evt (release_evt),
      .irq_en      (irq_en),
      .irq_ack     (irq_ack),
      .irq_pend    (irq_pend),
      .irq         (irq)
   );

   initial core_clk = 1'b0;
   always #5 core_clk = ~core_clk;

   // Advance one rising edge; outputs are then sampled 1ns after it.
   task automatic tick();
      @(posedge core_clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", tag, got);
      end
   endtask

   // All outputs packed: {btn_state, press_evt, release_evt, irq_pend, irq}
   function automatic logic [31:0] all_out();
      return {11'd0, btn_state, press_evt, release_evt, irq_pend, irq};
   endfunction

   int press3_count;
   int press3_edge;

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      core_rst = 1'b1;
      btn_in   = 5'b11111;
      irq_en   = 5'b00000;
      irq_ack  = 5'b00000;

      // 1. Reset
      ticks(3);
      core_rst = 1'b0;
      check("reset_outputs", all_out(), 32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_hold", all_out(), 32'd0);
      end

      // 2. Press / release on bit 0
      btn_in[0] = 1'b0;
      irq_en    = 5'b00001;
      ticks(5);
      check("press_edge5_state", {27'd0, btn_state}, 32'h00);
      check("press_edge5_evt",   {27'd0, press_evt}, 32'h00);
      tick();
      check("press_edge6_state", {27'd0, btn_state}, 32'h01);
      check("press_edge6_evt",   {27'd0, press_evt}, 32'h01);
      check("press_edge6_pend",  {27'd0, irq_pend},  32'h00);
      tick();
      check("press_edge7_evt",   {27'd0, press_evt}, 32'h00);
      check("press_edge7_pend",  {27'd0, irq_pend},  32'h01);
      check("press_edge7_irq",   {31'd0, irq},       32'h1);
      btn_in[0] = 1'b1;
      ticks(5);
      check("rel_edge5_state",   {27'd0, btn_state},   32'h01);
      check("rel_edge5_evt",     {27'd0, release_evt}, 32'h00);
      tick();
      check("rel_edge6_state",   {27'd0, btn_state},   32'h00);
      check("rel_edge6_evt",     {27'd0, release_evt}, 32'h01);
      check("rel_edge6_press",   {27'd0, press_evt},   32'h00);
      tick();
      check("rel_edge7_evt",     {27'd0, release_evt}, 32'h00);
      check("rel_pend_kept",     {27'd0, irq_pend},    32'h01);
      irq_ack = 5'b00001;
      tick();
      irq_ack = 5'b00000;
      check("ack_pend",          {27'd0, irq_pend},    32'h00);
      check("ack_irq",           {31'd0, irq},         32'h0);

      // 3. Glitch rejection on bit 1 (3 cycles < 4-edge window)
      btn_in[1] = 1'b0;
      ticks(3);
      btn_in[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("glitch_quiet", all_out(), 32'd0);
      end

      // 4. Bounce on bit 3: 2-cycle levels, then hold pressed
      press3_count = 0;
      press3_edge  = -1;
      for (int i = 0; i < 6; i++) begin
         btn_in[3] = (i % 2 == 0) ? 1'b0 : 1'b1;
         for (int k = 0; k < 2; k++) begin
            tick();
            if (press_evt[3]) press3_count++;
         end
      end
      btn_in[3] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (press_evt[3]) begin
            press3_count++;
            press3_edge = k;
         end
      end
      check("bounce_press_count", press3_count, 32'd1);
      check("bounce_press_edge",  press3_edge,  32'd6);
      check("bounce_state",       {27'd0, btn_state}, 32'h08);
      check("bounce_pend",        {27'd0, irq_pend},  32'h08);

      // 5. Ack collides with press on bit 0; masked irq
      irq_en    = 5'b00000;
      btn_in[0] = 1'b0;
      ticks(6);
      check("coll_press_evt", {27'd0, press_evt}, 32'h01);
      irq_ack = 5'b00001;
      tick();
      irq_ack = 5'b00000;
      check("coll_pend_kept", {27'd0, irq_pend}, 32'h09);
      check("coll_irq_masked", {31'd0, irq}, 32'h0);
      irq_en = 5'b00001;
      #1;
      check("enable_irq_now", {31'd0, irq}, 32'h1);

      // 6. Buttons held through reset (bits 0, 2, 3 pressed)
      btn_in[2] = 1'b0;
      core_rst  = 1'b1;
      ticks(2);
      core_rst  = 1'b0;
      check("rst2_cleared", all_out(), 32'd0);
      tick();
      check("rst2_edge1_quiet", all_out(), 32'd0);
      ticks(4);
      check("rst2_edge5_state", {27'd0, btn_state}, 32'h00);
      tick();
      check("rst2_edge6_state", {27'd0, btn_state}, 32'h0D);
      check("rst2_edge6_press", {27'd0, press_evt}, 32'h0D);

      // Reset pulsed mid-debounce on bit 4 restarts the full latency
      btn_in[4] = 1'b0;
      ticks(3);
      core_rst = 1'b1;
      tick();
      core_rst = 1'b0;
      check("rst3_cleared", all_out(), 32'd0);
      ticks(5);
      check("rst3_edge5_state", {27'd0, btn_state}, 32'h00);
      tick();
      check("rst3_edge6_state", {27'd0, btn_state}, 32'h1D);
      check("rst3_edge6_press", {27'd0, press_evt}, 32'h1D);
      tick();
      check("rst3_edge7_pend",  {27'd0, irq_pend},  32'h1D);
      check("rst3_edge7_irq",   {31'd0, irq},       32'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
